tx_resp_arbiter: RTL and testbench

- Sits in the REF_CLK domain between the system controller's response sources and the write port of the UART TX async FIFO.
- Captures one-cycle register-file read responses (8-bit) and ALU results (16-bit), and arbitrates between them round-robin.
- Splits ALU results into LSB then MSB bytes.
- Issues single-cycle FIFO write strobes, never while FIFO_FULL is high.

---
 rtl/tx_resp_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_tx_resp_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_resp_arbiter.sv
// Purpose : captures RF read responses and ALU results, arbitrates round-robin
//           and writes them byte-wise (ALU as LSB then MSB) into the UART TX FIFO.
// Latency : strobe in cycle N -> first FIFO write in cycle N+2; at most one byte per 2 cycles.
// Backpressure: i_fifo_full is sampled in IDLE/HI only; a strobe for a source that is
//           still pending (and not released that cycle) is dropped and flagged on o_ovf_err.
//
// Ports:
//   i_clk          REF_CLK domain clock
//   i_rst_n        asynchronous active-low reset
//   i_rf_rd_data   register-file read data, qualified by i_rf_rd_vld (1-cycle strobe)
//   i_alu_out      ALU result (2*DATA_WIDTH), qualified by i_alu_out_vld (1-cycle strobe)
//   i_fifo_full    async FIFO write-side full flag
//   o_tx_data      FIFO write data (registered, holds between writes)
//   o_tx_vld       FIFO write increment (registered, one cycle per byte)
//   o_busy         a response is pending or a transfer is in flight
//   o_ovf_err      one-cycle pulse when an incoming response is dropped
module tx_resp_arbiter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [DATA_WIDTH-1:0]   i_rf_rd_data,
   input  logic                    i_rf_rd_vld,
   input  logic [2*DATA_WIDTH-1:0] i_alu_out,
   input  logic                    i_alu_out_vld,
   input  logic                    i_fifo_full,
   output logic [DATA_WIDTH-1:0]   o_tx_data,
   output logic                    o_tx_vld,
   output logic                    o_busy,
   output logic                    o_ovf_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GAP    = 2'd1,
      S_GAP_HI = 2'd2,
      S_HI     = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic                    r_rf_pend;
   logic [DATA_WIDTH-1:0]   r_rf_hold;
   logic                    r_alu_pend;
   logic [2*DATA_WIDTH-1:0] r_alu_hold;
   logic                    r_last_alu;   // 1: last grant went to ALU

   logic [DATA_WIDTH-1:0]   r_tx_data;
   logic                    r_tx_vld;
   logic                    r_ovf_err;

   logic                    w_grant_rf;
   logic                    w_grant_alu;
   logic                    w_send_hi;
   logic                    w_tx_vld_nxt;
   logic [DATA_WIDTH-1:0]   w_tx_data_nxt;

   logic                    w_rf_cap;
   logic                    w_rf_drop;
   logic                    w_alu_cap;
   logic                    w_alu_drop;

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant_rf) begin
               w_state_nxt = S_GAP;
            end else if (w_grant_alu) begin
               w_state_nxt = S_GAP_HI;
            end
         end
         // Gap cycles give the FIFO full flag time to reflect the byte just written.
         S_GAP:    w_state_nxt = S_IDLE;
         S_GAP_HI: w_state_nxt = S_HI;
         S_HI: begin
            if (w_send_hi) begin
               w_state_nxt = S_GAP;
            end
         end
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: output / grant logic
   // ---------------------------------------------------------------
   always_comb begin
      w_grant_rf    = 1'b0;
      w_grant_alu   = 1'b0;
      w_send_hi     = 1'b0;
      w_tx_vld_nxt  = 1'b0;
      w_tx_data_nxt = r_tx_data;
      case (r_state)
         S_IDLE: begin
            if (!i_fifo_full) begin
               // On a tie the source that did not win last time goes first.
               if (r_rf_pend && (!r_alu_pend || r_last_alu)) begin
                  w_grant_rf = 1'b1;
               end else if (r_alu_pend) begin
                  w_grant_alu = 1'b1;
               end
            end
         end
         S_HI: begin
            if (!i_fifo_full) begin
               w_send_hi = 1'b1;
            end
         end
         default: ;
      endcase

      if (w_grant_rf) begin
         w_tx_vld_nxt  = 1'b1;
         w_tx_data_nxt = r_rf_hold;
      end else if (w_grant_alu) begin
         w_tx_vld_nxt  = 1'b1;
         w_tx_data_nxt = r_alu_hold[DATA_WIDTH-1:0];
      end else if (w_send_hi) begin
         w_tx_vld_nxt  = 1'b1;
         w_tx_data_nxt = r_alu_hold[2*DATA_WIDTH-1:DATA_WIDTH];
      end
   end

   // ---------------------------------------------------------------
   // Capture: a source releasing its slot this cycle may accept a new
   // strobe in the same cycle; otherwise a strobe on a busy slot is lost.
   // The ALU slot is only released when the MSB goes out, so its holding
   // register stays stable across the whole two-byte transfer.
   // ---------------------------------------------------------------
   assign w_rf_cap   = i_rf_rd_vld   && (!r_rf_pend  || w_grant_rf);
   assign w_rf_drop  = i_rf_rd_vld   &&   r_rf_pend  && !w_grant_rf;
   assign w_alu_cap  = i_alu_out_vld && (!r_alu_pend || w_send_hi);
   assign w_alu_drop = i_alu_out_vld &&   r_alu_pend && !w_send_hi;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rf_pend  <= 1'b0;
         r_rf_hold  <= '0;
      end else begin
         if (w_rf_cap) begin
            r_rf_pend <= 1'b1;
            r_rf_hold <= i_rf_rd_data;
         end else if (w_grant_rf) begin
            r_rf_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_alu_pend <= 1'b0;
         r_alu_hold <= '0;
      end else begin
         if (w_alu_cap) begin
            r_alu_pend <= 1'b1;
            r_alu_hold <= i_alu_out;
         end else if (w_send_hi) begin
            r_alu_pend <= 1'b0;
         end
      end
   end

   // Reset value "ALU" makes RF win the first tie.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last_alu <= 1'b1;
      end else if (w_grant_rf) begin
         r_last_alu <= 1'b0;
      end else if (w_grant_alu) begin
         r_last_alu <= 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Registered outputs
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx_data <= '0;
         r_tx_vld  <= 1'b0;
         r_ovf_err <= 1'b0;
      end else begin
         r_tx_data <= w_tx_data_nxt;
         r_tx_vld  <= w_tx_vld_nxt;
         r_ovf_err <= w_rf_drop | w_alu_drop;
      end
   end

   assign o_tx_data = r_tx_data;
   assign o_tx_vld  = r_tx_vld;
   assign o_ovf_err = r_ovf_err;
   // Built from flops only, so it cannot glitch on input activity.
   assign o_busy    = r_rf_pend | r_alu_pend | (r_state != S_IDLE);

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Purpose : self-checking bench for tx_resp_arbiter (vector table + corner sequences).
// Latency : expects first byte 2 cycles after a strobe, 2 cycles between bytes.
// Backpressure: drives FIFO_FULL and checks no write follows a full sample.
module tb_tx_resp_arbiter;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rf_rd_data;
   logic        rf_rd_vld;
   logic [15:0] alu_out;
   logic        alu_out_vld;
   logic        fifo_full;
   logic [7:0]  tx_data;
   logic        tx_vld;
   logic        busy;
   logic        ovf_err;

   tx_resp_arbiter #(.DATA_WIDTH(8)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_rf_rd_data  (rf_rd_data),
      .i_rf_rd_vld   (rf_rd_vld),
      .i_alu_out     (alu_out),
      .i_alu_out_vld (alu_out_vld),
      .i_fifo_full   (fifo_full),
      .o_tx_data     (tx_data),
      .o_tx_vld      (tx_vld),
      .o_busy        (busy),
      .o_ovf_err     (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   int ovf_cnt = 0;

   typedef struct {
      logic [7:0] dat;
      int         cyc;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        rf_vld;
      logic [7:0]  rf_dat;
      logic        alu_vld;
      logic [15:0] alu_dat;
      int          n;
      logic [23:0] bytes;   // {third, second, first} byte written
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input int c);
      exp_t e;
      e.dat = d;
      e.cyc = c;
      sb.push_back(e);
   endtask

   // Monitor: scoreboard compare on every FIFO write plus protocol checks.
   logic       prev_vld  = 1'b0;
   logic       prev_full = 1'b0;
   logic [7:0] last_dat  = 8'h00;
   always @(negedge clk) begin
      if (rst_n) begin
         if (tx_vld) begin
            chk("no_back_to_back", {31'b0, prev_vld}, 32'd0);
            chk("no_write_after_full", {31'b0, prev_full}, 32'd0);
            if (sb.size() == 0) begin
               chk("unexpected_write", {24'b0, tx_data}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("tx_data", {24'b0, tx_data}, {24'b0, e.dat});
               chk("tx_cycle", cyc, e.cyc);
            end
            last_dat = tx_data;
         end else begin
            chk("tx_data_hold", {24'b0, tx_data}, {24'b0, last_dat});
         end
         if (ovf_err) ovf_cnt++;
         prev_vld  = tx_vld;
         prev_full = fifo_full;
      end else begin
         prev_vld  = 1'b0;
         prev_full = 1'b0;
         last_dat  = 8'h00;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int ovf0;

      // RF tie-break, single sources, round-robin alternation.
      vecs[0] = '{1'b1, 8'hA5, 1'b0, 16'h0000, 1, 24'h0000A5};
      vecs[1] = '{1'b0, 8'h00, 1'b1, 16'h1234, 2, 24'h001234};
      vecs[2] = '{1'b1, 8'h5A, 1'b1, 16'hBEEF, 3, 24'hBEEF5A};
      vecs[3] = '{1'b1, 8'h99, 1'b0, 16'h0000, 1, 24'h000099};
      vecs[4] = '{1'b1, 8'h11, 1'b1, 16'h2233, 3, 24'h112233};
      vecs[5] = '{1'b1, 8'hC3, 1'b1, 16'hD4E5, 3, 24'hC3D4E5};
      vecs[6] = '{1'b0, 8'h00, 1'b1, 16'h00FF, 2, 24'h0000FF};

      rst_n       = 1'b0;
      rf_rd_data  = 8'h00;
      rf_rd_vld   = 1'b0;
      alu_out     = 16'h0000;
      alu_out_vld = 1'b0;
      fifo_full   = 1'b0;
      tick();
      tick();
      chk("rst_tx_vld",  {31'b0, tx_vld},  32'd0);
      chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
      chk("rst_busy",    {31'b0, busy},    32'd0);
      chk("rst_ovf",     {31'b0, ovf_err}, 32'd0);
      rst_n = 1'b1;
      tick();
      tick();

      // ---------------- table-driven vectors ----------------
      for (int v = 0; v < 7; v++) begin
         c0 = cyc;
         rf_rd_vld   = vecs[v].rf_vld;
         rf_rd_data  = vecs[v].rf_dat;
         alu_out_vld = vecs[v].alu_vld;
         alu_out     = vecs[v].alu_dat;
         for (int i = 0; i < vecs[v].n; i++) begin
            logic [23:0] b;
            b = vecs[v].bytes;
            push(b[8*i +: 8], c0 + 2 + 2*i);
         end
         tick();
         rf_rd_vld   = 1'b0;
         alu_out_vld = 1'b0;
         while (cyc < c0 + 2*vecs[v].n) tick();
         chk("busy_last_byte", {31'b0, busy}, 32'd1);
         tick();
         chk("busy_done", {31'b0, busy}, 32'd0);
         chk("sb_empty", sb.size(), 32'd0);
         tick();
      end

      // -------- same-cycle release and new RF strobe: no overflow --------
      ovf0 = ovf_cnt;
      c0 = cyc;
      rf_rd_vld = 1'b1; rf_rd_data = 8'h3C;
      push(8'h3C, c0 + 2);
      tick();
      rf_rd_data = 8'hC3;
      push(8'hC3, c0 + 4);
      tick();
      rf_rd_vld = 1'b0;
      while (cyc < c0 + 6) tick();
      chk("release_recapture_sb", sb.size(), 32'd0);
      chk("release_recapture_ovf", ovf_cnt - ovf0, 32'd0);
      chk("release_recapture_busy", {31'b0, busy}, 32'd0);
      tick();

      // -------- FIFO full while ALU MSB waits in HI --------
      c0 = cyc;
      alu_out_vld = 1'b1; alu_out = 16'hCAFE;
      push(8'hFE, c0 + 2);
      // Full is low again in cycle c0+12; HI samples it then and writes next cycle.
      push(8'hCA, c0 + 13);
      tick();
      alu_out_vld = 1'b0;
      tick();
      fifo_full = 1'b1;
      while (cyc < c0 + 8) tick();
      chk("full_hold_busy", {31'b0, busy}, 32'd1);
      chk("full_hold_sb", sb.size(), 32'd1);
      while (cyc < c0 + 12) tick();
      fifo_full = 1'b0;
      while (cyc < c0 + 15) tick();
      chk("full_release_sb", sb.size(), 32'd0);
      chk("full_release_busy", {31'b0, busy}, 32'd0);

      // -------- overflow: second RF strobe while first still pending --------
      ovf0 = ovf_cnt;
      fifo_full = 1'b1;
      tick();
      rf_rd_vld = 1'b1; rf_rd_data = 8'h01;
      tick();
      rf_rd_vld = 1'b0;
      tick();
      rf_rd_vld = 1'b1; rf_rd_data = 8'h02;
      tick();
      rf_rd_vld = 1'b0;
      tick();
      tick();
      chk("ovf_pulse_once", ovf_cnt - ovf0, 32'd1);
      chk("ovf_busy_while_full", {31'b0, busy}, 32'd1);
      fifo_full = 1'b0;
      push(8'h01, cyc + 1);
      repeat (5) tick();
      chk("ovf_sb_empty", sb.size(), 32'd0);
      chk("ovf_busy_done", {31'b0, busy}, 32'd0);

      // -------- reset in GAP_HI after the LSB of 0x7788 --------
      c0 = cyc;
      alu_out_vld = 1'b1; alu_out = 16'h7788;
      push(8'h88, c0 + 2);
      tick();
      alu_out_vld = 1'b0;
      @(posedge clk);          // enter cycle c0+2 (LSB on the bus, state GAP_HI)
      #7;                      // after the monitor has seen the LSB
      rst_n = 1'b0;
      #1;
      chk("midrst_tx_vld",  {31'b0, tx_vld},  32'd0);
      chk("midrst_tx_data", {24'b0, tx_data}, 32'd0);
      chk("midrst_busy",    {31'b0, busy},    32'd0);
      chk("midrst_sb",      sb.size(),        32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("postrst_busy", {31'b0, busy}, 32'd0);
      chk("postrst_sb", sb.size(), 32'd0);

      chk("total_ovf", ovf_cnt, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
